// File: rtl/uart_byte_tx_if.sv
// Handshake between a byte source and the UART transmitter: the byte, its start strobe,
// and the busy/done status returned to the source.
interface uart_byte_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter, 8N1 LSB first, started on a rising edge of tx_start.
// Define UART_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) before stop.
module uart_byte_tx #(
    parameter int unsigned CLK_HZ     = 25_000_000,
`ifdef UART_PARITY_EN
    parameter bit          PARITY_ODD = 1'b0,
`endif
    parameter int unsigned BAUD       = 115_200
) (
    input  logic            ext_clk_25m,
    input  logic            ext_rst_n,
    uart_byte_tx_if.slave   tx_if,
    output logic            uart_tx
);

    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
    localparam int unsigned CntW     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CntW-1:0] DivLast = CntW'(BAUD_DIV - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] StParity = 3'd4;
`endif

    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_byte_tx: CLK_HZ/BAUD must be at least 2");
    end

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            start_q;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            accept;
    logic            bit_end;
`ifdef UART_PARITY_EN
    logic            parity_q, parity_d;
`endif

    assign accept  = tx_if.tx_start & ~start_q & (state_q == StIdle);
    assign bit_end = (baud_cnt_q == DivLast);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
`ifdef UART_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != StIdle) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StStart;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = tx_if.tx_data;
`ifdef UART_PARITY_EN
                    parity_d   = (^tx_if.tx_data) ^ PARITY_ODD;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level is registered from the next state so uart_tx tracks state_q exactly.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // start_q resets high so a strobe already held at reset release is not an edge.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            start_q    <= 1'b1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            start_q    <= tx_if.tx_start;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign uart_tx       = tx_q;
    assign tx_if.tx_busy = busy_q;
    assign tx_if.tx_done = done_q;

endmodule
